// File: rtl/hazard_ctrl.sv
// hazard_ctrl -- pipeline hazard and fetch-wait controller.
//
// Combines three concerns into one set of Mealy control outputs:
//   * boot sequencing after reset (2 cycles with fetch disabled),
//   * load-use stalls between Execute and Decode,
//   * instruction-memory wait handling, including a redirect (PCSrcE) that
//     lands while a fetch is outstanding: the fetch still in flight is for
//     the old path and must be dropped when it finally arrives.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   Rs1D, Rs2D             source registers of the instruction in Decode
//   RdE, LoadE             destination / is-load of the instruction in Execute
//   PCSrcE                 taken branch or jump resolved in Execute
//   ImemReady              instruction memory returns InstrF this cycle
//   ImemReq                fetch request to instruction memory
//   StallF, StallD         hold PC / hold the F/D register
//   FlushD, FlushE         bubble the F/D / D/E register
//   StallCount             saturating count of non-boot cycles with StallF=1
module hazard_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  Rs1D,
  input  logic [4:0]  Rs2D,
  input  logic [4:0]  RdE,
  input  logic        LoadE,
  input  logic        PCSrcE,
  input  logic        ImemReady,
  output logic        ImemReq,
  output logic        StallF,
  output logic        StallD,
  output logic        FlushD,
  output logic        FlushE,
  output logic [15:0] StallCount
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        boot_cnt_q, boot_cnt_d;
  logic        drop_next_q, drop_next_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  logic luh;
  logic hold_d;

  // x0 is never a real destination, so a load to it cannot create a hazard.
  assign luh = LoadE & (RdE != 5'd0) & ((RdE == Rs1D) | (RdE == Rs2D));

  // While fetch is blocked, a pending load-use keeps the Decode instruction
  // in place instead of bubbling it; a redirect overrides that.
  assign hold_d = luh & ~PCSrcE;

  always_comb begin
    // Boot values double as the safe default.
    ImemReq     = 1'b0;
    StallF      = 1'b1;
    StallD      = 1'b0;
    FlushD      = 1'b1;
    FlushE      = 1'b1;
    state_d     = state_q;
    boot_cnt_d  = boot_cnt_q;
    drop_next_d = drop_next_q;

    unique case (state_q)
      ST_BOOT: begin
        // Two edges in BOOT: the first sets boot_cnt, the second leaves.
        boot_cnt_d  = ~boot_cnt_q;
        drop_next_d = 1'b0;
        if (boot_cnt_q) state_d = ST_RUN;
      end

      ST_RUN, ST_WAIT: begin
        ImemReq = 1'b1;
        if (ImemReady) begin
          state_d     = ST_RUN;
          // A returning fetch always consumes the drop; a redirect in this
          // same cycle does not need it because this fetch is discarded too.
          drop_next_d = 1'b0;
          if (drop_next_q) begin
            // Stale fetch from the pre-redirect path: bubble it and let the
            // PC advance to the redirected target.
            StallF = 1'b0;
            StallD = 1'b0;
            FlushD = 1'b1;
            FlushE = PCSrcE | luh;
          end else if (PCSrcE) begin
            // Redirect wins over load-use: both younger stages are wrong-path.
            StallF = 1'b0;
            StallD = 1'b0;
            FlushD = 1'b1;
            FlushE = 1'b1;
          end else if (luh) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushD = 1'b0;
            FlushE = 1'b1;
          end else begin
            StallF = 1'b0;
            StallD = 1'b0;
            FlushD = 1'b0;
            FlushE = 1'b0;
          end
        end else begin
          // Fetch outstanding: hold PC, bubble F/D unless Decode must be
          // preserved for a load-use, and remember any redirect so the
          // in-flight (old-path) fetch is dropped when it lands.
          state_d     = ST_WAIT;
          drop_next_d = drop_next_q | PCSrcE;
          StallF      = 1'b1;
          StallD      = hold_d;
          FlushD      = ~hold_d;
          FlushE      = PCSrcE | luh;
        end
      end

      default: begin
        state_d     = ST_BOOT;
        boot_cnt_d  = 1'b0;
        drop_next_d = 1'b0;
      end
    endcase
  end

  // Stall cycles during BOOT are not counted; the counter pins at all-ones.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (StallF && (state_q != ST_BOOT) && (stall_cnt_q != 16'hFFFF))
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_BOOT;
      boot_cnt_q  <= 1'b0;
      drop_next_q <= 1'b0;
      stall_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      boot_cnt_q  <= boot_cnt_d;
      drop_next_q <= drop_next_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign StallCount = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios with literal
// expectations, then randomized traffic (with occasional async resets) and a
// long saturation run, all compared every cycle against a behavioural model.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  Rs1D, Rs2D, RdE;
  logic        LoadE, PCSrcE, ImemReady;
  logic        ImemReq, StallF, StallD, FlushD, FlushE;
  logic [15:0] StallCount;

  hazard_ctrl dut (
    .clk(clk), .rst_n(rst_n), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdE(RdE),
    .LoadE(LoadE), .PCSrcE(PCSrcE), .ImemReady(ImemReady),
    .ImemReq(ImemReq), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
    .FlushE(FlushE), .StallCount(StallCount)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Control vector order: {ImemReq, StallF, StallD, FlushD, FlushE}
  wire [4:0] ctl = {ImemReq, StallF, StallD, FlushD, FlushE};

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_boot_edges;   // edges seen since reset release (BOOT while < 2)
  bit m_drop;         // a redirect arrived while a fetch was outstanding
  int m_cnt;          // stall cycle count, saturating

  function automatic logic [4:0] model_ctl(input bit boot, input bit drop,
      input bit ready, input bit pcsrc, input bit loade,
      input logic [4:0] rde, input logic [4:0] rs1, input logic [4:0] rs2);
    bit luh, keep;
    if (boot) return 5'b01011;
    luh = loade && (rde != 0) && (rde == rs1 || rde == rs2);
    if (!ready) begin
      keep = luh && !pcsrc;
      return {1'b1, 1'b1, keep, !keep, pcsrc || luh};
    end
    if (drop)  return {4'b1001, pcsrc || luh};
    if (pcsrc) return 5'b10011;
    if (luh)   return 5'b11101;
    return 5'b10000;
  endfunction

  function automatic logic [4:0] model_now();
    if (!rst_n) return 5'b01011;
    return model_ctl(m_boot_edges < 2, m_drop, ImemReady, PCSrcE, LoadE, RdE, Rs1D, Rs2D);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    logic [4:0] e;
    if (!rst_n) begin
      m_boot_edges = 0;
      m_drop       = 0;
      m_cnt        = 0;
    end else begin
      e = model_now();
      if (m_boot_edges < 2) begin
        m_boot_edges++;
      end else begin
        if (e[3] && m_cnt < 65535) m_cnt++;
        m_drop = ImemReady ? 1'b0 : (m_drop || PCSrcE);
      end
    end
  end

  // Single per-cycle compare, away from the active edge.
  always @(negedge clk) begin
    chk("ctl_vs_model", {11'b0, ctl}, {11'b0, model_now()});
    chk("count_vs_model", StallCount, m_cnt[15:0]);
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input bit ready, input bit pcsrc, input bit loade,
                        input logic [4:0] rde, input logic [4:0] rs1, input logic [4:0] rs2);
    ImemReady = ready;
    PCSrcE    = pcsrc;
    LoadE     = loade;
    RdE       = rde;
    Rs1D      = rs1;
    Rs2D      = rs2;
  endtask

  initial begin
    set_in(1, 0, 0, 0, 0, 0);
    // Reset held for 3 cycles.
    #1;
    chk("reset_ctl", {11'b0, ctl}, 16'h000B);
    chk("reset_count", StallCount, 16'h0000);
    repeat (3) tick();
    chk("reset_ctl_held", {11'b0, ctl}, 16'h000B);
    rst_n = 1'b1;
    #1 chk("boot_ctl_0", {11'b0, ctl}, 16'h000B);
    tick();
    chk("boot_ctl_1", {11'b0, ctl}, 16'h000B);
    tick();
    chk("run_first_ctl", {11'b0, ctl}, 16'h0010);
    chk("run_first_count", StallCount, 16'h0000);

    // Load-use: one stall cycle.
    set_in(1, 0, 1, 5, 1, 5);
    #1 chk("luh_ctl", {11'b0, ctl}, 16'h001D);
    tick();
    chk("luh_count", StallCount, 16'd1);
    chk("model_pin_luh", m_cnt[15:0], 16'd1);
    // RdE=0 never stalls.
    set_in(1, 0, 1, 0, 0, 0);
    #1 chk("luh_x0_ctl", {11'b0, ctl}, 16'h0010);
    tick();
    chk("luh_x0_count", StallCount, 16'd1);

    // Branch wins over load-use.
    set_in(1, 1, 1, 5, 5, 1);
    #1 chk("br_luh_ctl", {11'b0, ctl}, 16'h0013);
    tick();
    chk("br_luh_count", StallCount, 16'd1);

    // Memory wait, redirect in 2nd cycle.
    set_in(0, 0, 0, 0, 0, 0);
    #1 chk("wait1_ctl", {11'b0, ctl}, 16'h001A);
    tick();
    set_in(0, 1, 0, 0, 0, 0);
    #1 chk("wait2_ctl", {11'b0, ctl}, 16'h001B);
    tick();
    set_in(0, 0, 0, 0, 0, 0);
    #1 chk("wait3_ctl", {11'b0, ctl}, 16'h001A);
    tick();
    #1 chk("wait4_ctl", {11'b0, ctl}, 16'h001A);
    tick();
    set_in(1, 0, 0, 0, 0, 0);
    #1 chk("drop_ctl", {11'b0, ctl}, 16'h0012);
    chk("wait_count", StallCount, 16'd5);
    chk("model_pin_wait", m_cnt[15:0], 16'd5);
    tick();
    #1 chk("drop_cleared_ctl", {11'b0, ctl}, 16'h0010);
    tick();

    // Async reset while waiting with a pending drop.
    set_in(0, 1, 0, 0, 0, 0);
    tick();
    set_in(0, 0, 0, 0, 0, 0);
    #1 rst_n = 1'b0;
    #1 chk("midwait_rst_ctl", {11'b0, ctl}, 16'h000B);
    chk("midwait_rst_count", StallCount, 16'h0000);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    set_in(1, 0, 0, 0, 0, 0);
    #1 chk("post_rst_no_drop", {11'b0, ctl}, 16'h0010);
    chk("post_rst_count", StallCount, 16'h0000);
    tick();

    // Randomized traffic, small register range so hazards are frequent.
    repeat (3000) begin
      tick();
      set_in($urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0,
             $urandom_range(0, 1) == 1, 5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
      if (rst_n && $urandom_range(0, 299) == 0) begin
        #2 rst_n = 1'b0;
      end else if (!rst_n && $urandom_range(0, 1) == 1) begin
        rst_n = 1'b1;
      end
    end
    tick();
    rst_n = 1'b1;
    repeat (3) tick();

    // Saturation.
    set_in(0, 0, 0, 0, 0, 0);
    repeat (70000) tick();
    chk("sat_count", StallCount, 16'hFFFF);
    chk("sat_ctl", {11'b0, ctl}, 16'h001A);
    tick();
    chk("sat_no_wrap", StallCount, 16'hFFFF);
    set_in(1, 0, 0, 0, 0, 0);
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
